l1d_axi_master_bridge: RTL
==========================

// Module: l1d_axi_master_bridge
// PURPOSE
//  Cache-side responder / AXI4 master for the L1 data cache. Accepts line-fill reads (D_req) and
//  write-through single-word writes (D_write) from the cache. Issues them as AXI4 INCR read bursts
//  and single-beat writes, then returns beats and write responses on the cache's RVALID/RLAST/BVALID/BREADY.
//  Sits between the L1 data cache and the CPU wrapper's data-side AXI master port.
// PARAMETERS
//  BURST_LEN  4   read beats per line fill (ARLEN = BURST_LEN-1); power of two, 1..16
//  ADDR_W     32  address width
//  DATA_W     32  data width (ARSIZE/AWSIZE = 3'b010)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-high
//  D_req       in   1       cache read request (level; held through the burst)
//  D_write     in   1       cache write request (level; held until B handshake)
//  D_addr      in   ADDR_W  request byte address
//  D_in        in   DATA_W  write data
//  D_type      in   4       byte write-enables, active-low (0 = write byte)
//  D_out       out  DATA_W  read beat data to cache (= RDATA, combinational)
//  c_rvalid    out  1       beat accepted this cycle (RVALID & RREADY)
//  c_rlast     out  1       last beat accepted this cycle (c_rvalid & RLAST)
//  c_bvalid    out  1       write response accepted (BVALID, gated by BREADY)
//  c_bready    out  1       mirrors BREADY
//  err         out  1       sticky: non-OKAY resp or burst-length violation; cleared only by rst
//  ARADDR      out  ADDR_W  {D_addr[ADDR_W-1:log2(BURST_LEN*4)], 0}, registered
//  ARLEN/ARSIZE/ARBURST  out  4/3/2  constants BURST_LEN-1 / 3'b010 / 2'b01 (INCR)
//  ARVALID     out  1       read address valid
//  ARREADY     in   1       read address ready
//  RDATA       in   DATA_W  read data
//  RRESP       in   2       read response
//  RLAST       in   1       last read beat
//  RVALID      in   1       read data valid
//  RREADY      out  1       read data ready
//  AWADDR      out  ADDR_W  {D_addr[ADDR_W-1:2],2'b00}, registered
//  AWLEN/AWSIZE/AWBURST  out  4/3/2  constants 0 / 3'b010 / 2'b01
//  AWVALID     out  1       write address valid
//  AWREADY     in   1       write address ready
//  WDATA       out  DATA_W  latched D_in
//  WSTRB       out  4       ~latched D_type
//  WLAST       out  1       tied 1
//  WVALID      out  1       write data valid
//  WREADY      in   1       write data ready
//  BRESP       in   2       write response
//  BVALID      in   1       write response valid
//  BREADY      out  1       write response ready
// BEHAVIOUR
//  Reset (async): state=IDLE; all VALID/READY outputs 0; ARADDR/AWADDR/WDATA 0; WSTRB 0; beat_cnt 0; err 0.
//  FSM states: IDLE, AR, R, AWW, B.
//  IDLE: D_write=1 -> latch addr/D_in/D_type, go AWW (AWVALID=WVALID=1 next cycle).
//    Else D_req=1 -> latch aligned addr, go AR. D_write has priority when both are high.
//  AR: ARVALID=1 until ARREADY. Handshake -> R; ARVALID drops the next cycle.
//  R: RREADY=1. Each RVALID beat increments beat_cnt.
//    On RLAST: check beat_cnt==BURST_LEN-1, else set err. Go IDLE; beat_cnt=0.
//    Beat with beat_cnt==BURST_LEN-1 and !RLAST: set err, stay in R until RLAST.
//  AWW: AWVALID and WVALID are independent; each drops after its own handshake (either order, or same cycle).
//    Both done -> B.
//  B: BREADY=1. BVALID -> IDLE.
//  err: set on any accepted beat with RRESP!=0 or BRESP!=0.
//  Latency: IDLE->ARVALID 1 cycle. D_out/c_rvalid/c_rlast/c_bvalid are combinational from the AXI inputs,
//    so the cache sees each beat in its accept cycle.
//  The cache still holds D_req/D_write during the completing handshake cycle. No relaunch occurs:
//    the FSM is busy in that cycle and the cache drops the request in the next one.
//  Latched fields do not change while not in IDLE. D_addr/D_in changes mid-transaction are ignored.
//  Valid signals are never withdrawn before their handshake (AXI rule).
// TESTING
//  Read, zero wait: D_req, D_addr=0x0000_1234 -> ARADDR=0x0000_1230, ARLEN=3. 4 beats 0xA0..0xA3
//    -> c_rvalid x4, c_rlast on the 4th, back to IDLE, err=0.
//  Read with backpressure: ARREADY low 3 cycles, RVALID gaps -> ARVALID held stable.
//    c_rvalid only on RVALID cycles; D_out matches each beat.
//  Write: D_write, D_addr=0x8000_0006, D_in=0xDEADBEEF, D_type=4'b0011 -> AWADDR=0x8000_0004,
//    WSTRB=4'b1100, WLAST=1. BVALID -> c_bvalid one cycle, then IDLE.
//  AW/W skew: WREADY 2 cycles before AWREADY, then the reverse -> each valid drops only after its own
//    handshake. B entered only after both.
//  Errors: RLAST on beat 2 -> err=1. BRESP=2'b10 -> err=1. err stays 1 until rst.
//  Async rst asserted mid-R burst -> all VALID/READY low immediately.
//    After release, a D_req starts a fresh AR with beat_cnt=0.

Source files
------------

// File: rtl/l1d_axi_master_bridge.sv
// l1d_axi_master_bridge
// Connects the L1 data cache to the CPU wrapper's data-side AXI4 master port.
// Line-fill reads (D_req) become INCR bursts of BURST_LEN beats. Write-through
// single-word writes (D_write) become single-beat AW/W transactions with a
// byte strobe. Each read beat and each write response is passed straight back
// to the cache in the cycle the AXI handshake completes.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   D_req, D_write               cache read / write requests (level, held)
//   D_addr, D_in, D_type         request address, write data, active-low byte enables
//   D_out, c_rvalid, c_rlast     read beat data and accept strobes to the cache
//   c_bvalid, c_bready           write response accept strobe and BREADY mirror
//   err                          sticky error (bad response or burst length)
//   AR* / R*                     AXI4 read address and read data channels
//   AW* / W* / B*                AXI4 write address, write data and response channels
module l1d_axi_master_bridge #(
   parameter int BURST_LEN = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              D_req,
   input  logic              D_write,
   input  logic [ADDR_W-1:0] D_addr,
   input  logic [DATA_W-1:0] D_in,
   input  logic [3:0]        D_type,
   output logic [DATA_W-1:0] D_out,
   output logic              c_rvalid,
   output logic              c_rlast,
   output logic              c_bvalid,
   output logic              c_bready,
   output logic              err,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [3:0]        ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY,
   output logic [ADDR_W-1:0] AWADDR,
   output logic [3:0]        AWLEN,
   output logic [2:0]        AWSIZE,
   output logic [1:0]        AWBURST,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic [3:0]        WSTRB,
   output logic              WLAST,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY
);

   // Number of low address bits covered by one cache line.
   localparam int LINE_OFF = $clog2(BURST_LEN * 4);
   localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AWW,
      ST_B
   } state_t;

   state_t     state;
   logic [4:0] beat_cnt;

   // The word-offset bits of D_addr never reach either address channel.
   logic unused_addr_bits;
   assign unused_addr_bits = ^D_addr[1:0];

   assign ARLEN   = 4'(BURST_LEN - 1);
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign AWLEN   = 4'd0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign WLAST   = 1'b1;

   // Cache-side strobes are taken straight from the AXI handshakes so the
   // cache sees each beat/response in the very cycle it is accepted.
   assign D_out    = RDATA;
   assign c_rvalid = RVALID & RREADY;
   assign c_rlast  = RVALID & RREADY & RLAST;
   assign c_bvalid = BVALID & BREADY;
   assign c_bready = BREADY;

   // Single FSM with all handshake outputs registered. Latched request fields
   // are only written in IDLE, so changes on D_addr/D_in mid-transaction are
   // ignored. In R the beat counter saturates at the last beat: an overlong
   // burst flags err and waits for RLAST. In AWW each valid drops on its own
   // handshake; B is entered once neither valid is still pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         beat_cnt <= 5'd0;
         err      <= 1'b0;
         ARADDR   <= '0;
         AWADDR   <= '0;
         WDATA    <= '0;
         WSTRB    <= 4'b0000;
         ARVALID  <= 1'b0;
         RREADY   <= 1'b0;
         AWVALID  <= 1'b0;
         WVALID   <= 1'b0;
         BREADY   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               beat_cnt <= 5'd0;
               if (D_write) begin
                  AWADDR  <= {D_addr[ADDR_W-1:2], 2'b00};
                  WDATA   <= D_in;
                  WSTRB   <= ~D_type;
                  AWVALID <= 1'b1;
                  WVALID  <= 1'b1;
                  state   <= ST_AWW;
               end else if (D_req) begin
                  ARADDR  <= {D_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
                  ARVALID <= 1'b1;
                  state   <= ST_AR;
               end
            end
            ST_AR: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= ST_R;
               end
            end
            ST_R: begin
               if (RVALID) begin
                  if (RRESP != 2'b00) begin
                     err <= 1'b1;
                  end
                  if (RLAST) begin
                     if (beat_cnt != LAST_BEAT) begin
                        err <= 1'b1;
                     end
                     beat_cnt <= 5'd0;
                     RREADY   <= 1'b0;
                     state    <= ST_IDLE;
                  end else if (beat_cnt == LAST_BEAT) begin
                     err <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 5'd1;
                  end
               end
            end
            ST_AWW: begin
               if (AWVALID && AWREADY) begin
                  AWVALID <= 1'b0;
               end
               if (WVALID && WREADY) begin
                  WVALID <= 1'b0;
               end
               if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                  BREADY <= 1'b1;
                  state  <= ST_B;
               end
            end
            ST_B: begin
               if (BVALID) begin
                  if (BRESP != 2'b00) begin
                     err <= 1'b1;
                  end
                  BREADY <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
